// File: rtl/l1_lru_ctrl_if.sv
// Lookup / way-select bundle between the L1 pipeline (master) and the
// replacement manager (slave).
interface l1_lru_ctrl_if #(
  parameter int unsigned WAY_NUM   = 4,
  parameter int unsigned IDX_WIDTH = 6
);
  logic                 req;
  logic [IDX_WIDTH-1:0] idx;
  logic                 ready;
  logic [WAY_NUM-1:0]   tag_cmp_vect;
  logic [WAY_NUM-1:0]   ld_val_vect;
  logic                 hit;
  logic                 evict_val;
  logic [WAY_NUM-1:0]   way_vect;

  modport master (
    output req, idx, tag_cmp_vect, ld_val_vect,
    input  ready, hit, evict_val, way_vect
  );

  modport slave (
    input  req, idx, tag_cmp_vect, ld_val_vect,
    output ready, hit, evict_val, way_vect
  );
endinterface

// File: rtl/l1_lru_ctrl.sv
// Per-set way selection and tree pseudo-LRU replacement for a set-associative L1.
// Hit/victim decision is made the cycle after the lookup from the tag-memory vectors.
module l1_lru_ctrl #(
  parameter int unsigned WAY_NUM   = 4,
  parameter int unsigned SET_NUM   = 64,
  parameter int unsigned IDX_WIDTH = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  l1_lru_ctrl_if.slave   bus
);

  localparam int unsigned LVL    = $clog2(WAY_NUM);
  localparam int unsigned NODE_W = LVL + 1;
  localparam int unsigned TREE_W = 2 * WAY_NUM;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e               state_q;
  logic [IDX_WIDTH-1:0] init_cnt_q;
  logic [IDX_WIDTH-1:0] idx_r;
  logic                 req_r;
  logic                 ready_q;
  logic [WAY_NUM-2:0]   plru_q [SET_NUM];

  logic [WAY_NUM-2:0]   plru_cur;
  logic [WAY_NUM-2:0]   plru_upd;
  logic [TREE_W-1:0]    tree_cur;
  logic [WAY_NUM-1:0]   hitv;
  logic [WAY_NUM-1:0]   hit_sel;
  logic [WAY_NUM-1:0]   inv;
  logic [WAY_NUM-1:0]   inv_sel;
  logic [WAY_NUM-1:0]   vic_sel;
  logic [WAY_NUM-1:0]   sel;
  logic [WAY_NUM-1:0]   sel_shift;
  logic [NODE_W-1:0]    node;
  logic [LVL-1:0]       vic_idx;
  logic [LVL-1:0]       sel_idx;
  logic [LVL-1:0]       path;
  logic                 bit_dir;

  // Init sweep over all sets, then accept lookups; ready stays high until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
      req_r      <= 1'b0;
      idx_r      <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          req_r <= 1'b0;
          if (init_cnt_q == IDX_WIDTH'(SET_NUM - 1)) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end else begin
            init_cnt_q <= init_cnt_q + IDX_WIDTH'(1);
          end
        end
        ST_RUN: begin
          req_r <= bus.req;
          if (bus.req) begin
            idx_r <= bus.idx;
          end
        end
        default: begin
          state_q <= ST_INIT;
        end
      endcase
    end
  end

  // PLRU storage: cleared by the init sweep, never by reset.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      plru_q[init_cnt_q] <= '0;
    end else if (req_r) begin
      plru_q[idx_r] <= plru_upd;
    end
  end

  always_comb begin
    plru_cur = plru_q[idx_r];
    tree_cur = TREE_W'(plru_cur);

    hitv    = bus.tag_cmp_vect & bus.ld_val_vect;
    hit_sel = hitv & (~hitv + WAY_NUM'(1));
    inv     = ~bus.ld_val_vect;
    inv_sel = inv & (~inv + WAY_NUM'(1));

    // Victim: walk heap-indexed tree from the root, each bit names the colder half.
    node = '0;
    for (int l = 0; l < LVL; l++) begin
      node = {node[NODE_W-2:0], 1'b0} + NODE_W'(1) + NODE_W'(tree_cur[node]);
    end
    vic_idx = LVL'(node - NODE_W'(WAY_NUM - 1));
    vic_sel = WAY_NUM'(1) << vic_idx;

    if (|hitv) begin
      sel = hit_sel;
    end else if (|inv) begin
      sel = inv_sel;
    end else begin
      sel = vic_sel;
    end

    sel_idx   = '0;
    sel_shift = sel;
    for (int w = 0; w < WAY_NUM; w++) begin
      if (sel_shift[0]) begin
        sel_idx = LVL'(w);
      end
      sel_shift = sel_shift >> 1;
    end

    // Point every node on the path to the selected way away from it.
    plru_upd = plru_cur;
    node     = '0;
    path     = sel_idx;
    for (int l = 0; l < LVL; l++) begin
      bit_dir = path[LVL-1];
      for (int n = 0; n < WAY_NUM - 1; n++) begin
        if (node == NODE_W'(n)) begin
          plru_upd[n] = ~bit_dir;
        end
      end
      node = {node[NODE_W-2:0], 1'b0} + NODE_W'(1) + NODE_W'(bit_dir);
      path = path << 1;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.hit       = req_r & (|hitv);
  assign bus.evict_val = req_r & ~(|hitv) & ~(|inv);
  assign bus.way_vect  = req_r ? sel : '0;

endmodule

// File: tb/tb_l1_lru_ctrl.sv
// Bench for l1_lru_ctrl: directed and random lookups against a tree-PLRU reference model.
module tb_l1_lru_ctrl;
  localparam int unsigned WAY_NUM   = 4;
  localparam int unsigned SET_NUM   = 64;
  localparam int unsigned IDX_WIDTH = 6;
  localparam int          LVL       = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  l1_lru_ctrl_if #(.WAY_NUM(WAY_NUM), .IDX_WIDTH(IDX_WIDTH)) bus ();

  l1_lru_ctrl #(
    .WAY_NUM  (WAY_NUM),
    .SET_NUM  (SET_NUM),
    .IDX_WIDTH(IDX_WIDTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int       n_pass   = 0;
  int       n_total  = 0;
  int       cyc      = 0;
  bit       pend     = 1'b0;
  int       pend_idx = 0;
  bit [2:0] plru_m [SET_NUM];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic int lowest(input logic [3:0] x);
    for (int k = 0; k < 4; k++) if (x[k]) return k;
    return 0;
  endfunction

  function automatic int victim(input int s);
    int n = 0;
    for (int l = 0; l < LVL; l++) n = 2 * n + 1 + int'(plru_m[s][n]);
    return n - (int'(WAY_NUM) - 1);
  endfunction

  function automatic void touch(input int s, input int w);
    int n = 0;
    int b;
    for (int l = 0; l < LVL; l++) begin
      b = (w >> (LVL - 1 - l)) & 1;
      plru_m[s][n] = (b == 0);
      n = 2 * n + 1 + b;
    end
  endfunction

  // One clock: present a new request plus the tag vectors for the previous one.
  task automatic step(input bit r, input int i, input logic [3:0] cmp, input logic [3:0] val);
    int         ew;
    bit         eh, ee, acc;
    logic [3:0] hv;
    bus.req          = r;
    bus.idx          = IDX_WIDTH'(i);
    bus.tag_cmp_vect = cmp;
    bus.ld_val_vect  = val;
    @(negedge clk);
    chk("ready", 32'(bus.ready), 32'(cyc >= 64));
    if (pend) begin
      hv = cmp & val;
      if (hv != 4'b0) begin
        eh = 1'b1; ee = 1'b0; ew = lowest(hv);
      end else if (val != 4'hF) begin
        eh = 1'b0; ee = 1'b0; ew = lowest(~val);
      end else begin
        eh = 1'b0; ee = 1'b1; ew = victim(pend_idx);
      end
      chk("hit", 32'(bus.hit), 32'(eh));
      chk("evict_val", 32'(bus.evict_val), 32'(ee));
      chk("way_vect", 32'(bus.way_vect), 32'(1) << ew);
      touch(pend_idx, ew);
    end else begin
      chk("idle_hit", 32'(bus.hit), 32'd0);
      chk("idle_evict", 32'(bus.evict_val), 32'd0);
      chk("idle_way", 32'(bus.way_vect), 32'd0);
    end
    acc = r && (cyc >= 64);
    @(posedge clk);
    #1;
    cyc++;
    pend     = acc;
    pend_idx = i;
  endtask

  task automatic do_reset(input int hold);
    bus.req = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_hit", 32'(bus.hit), 32'd0);
    chk("rst_way", 32'(bus.way_vect), 32'd0);
    repeat (hold) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    pend  = 1'b0;
    for (int s = 0; s < SET_NUM; s++) plru_m[s] = '0;
  endtask

  initial begin
    logic [3:0] cmp, val;
    bus.req          = 1'b0;
    bus.idx          = '0;
    bus.tag_cmp_vect = '0;
    bus.ld_val_vect  = '0;
    rst_n            = 1'b0;

    do_reset(3);
    // Init window: requests must be ignored.
    for (int k = 0; k < 64; k++) step(bit'(k % 2), k, 4'($urandom), 4'($urandom));

    // Invalid-way fill selection.
    step(1'b1, 5, 4'b0000, 4'b0000);
    step(1'b1, 5, 4'b0000, 4'b0000);
    step(1'b0, 0, 4'b0000, 4'b0001);
    // Hit.
    step(1'b1, 5, 4'b0000, 4'b0000);
    step(1'b0, 0, 4'b0100, 4'b1111);
    // Set 9: touch ways 0..3, then two full-valid misses.
    step(1'b1, 9, 4'b0000, 4'b0000);
    step(1'b1, 9, 4'b0001, 4'b1111);
    step(1'b1, 9, 4'b0010, 4'b1111);
    step(1'b1, 9, 4'b0100, 4'b1111);
    step(1'b1, 9, 4'b1000, 4'b1111);
    step(1'b1, 9, 4'b0000, 4'b1111);
    step(1'b0, 0, 4'b0000, 4'b1111);
    // Back-to-back on set 3, then an untouched set.
    step(1'b1, 3, 4'b0000, 4'b0000);
    step(1'b1, 3, 4'b0001, 4'b1111);
    step(1'b1, 4, 4'b0000, 4'b1111);
    step(1'b0, 0, 4'b0000, 4'b1111);

    // Random traffic on a few sets to force reuse, including illegal multi-hit.
    for (int k = 0; k < 400; k++) begin
      val = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      case ($urandom_range(0, 3))
        0:       cmp = 4'b0000;
        1:       cmp = 4'($urandom);
        default: cmp = 4'b0001 << $urandom_range(0, 3);
      endcase
      step(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)), cmp, val);
    end

    // Reset in the middle of init restarts the sweep.
    do_reset(2);
    for (int k = 0; k < 30; k++) step(1'b1, k, 4'b0000, 4'b0000);
    do_reset(3);
    for (int k = 0; k < 64; k++) step(1'b0, 0, 4'b0000, 4'b0000);
    step(1'b1, 9, 4'b0000, 4'b0000);
    step(1'b0, 0, 4'b0000, 4'b1111);
    step(1'b0, 0, 4'b0000, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
